// File: rtl/cs_window_ctrl.sv
// Sequencer for the CS window datapath: fills a WIN-deep circular buffer and fires calc_en on every sample once the window is full.
// Result appears LAT cycles after calc_en. While Y is held it freezes the datapath (dp_en=0) and blocks input (in_ready=0).
module cs_window_ctrl #(
    parameter int WIN = 9,
    parameter int AW  = 4,
    parameter int LAT = 1,
    parameter int LW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] frame_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          calc_en,
    output logic          dp_en,
    output logic          busy,
    output logic          done
);
    localparam int FW = $clog2(WIN + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] acc_q, acc_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LAT-1:0] vpipe_q, vpipe_d;

    logic stall;
    logic accept;
    logic last_sample;

    assign out_valid   = vpipe_q[LAT-1];
    assign stall       = out_valid & ~out_ready;
    assign dp_en       = ~stall;
    assign in_ready    = ((state_q == S_FILL) || (state_q == S_RUN)) & ~stall & (acc_q < len_q);
    assign accept      = in_valid & in_ready;
    assign wr_en       = accept;
    assign wr_addr     = addr_q;
    // The 9th sample completes the window in the same cycle it is written.
    assign calc_en     = accept & ((fill_q == FW'(WIN - 1)) | (state_q == S_RUN));
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign last_sample = ((acc_q + LW'(1)) == len_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        len_d   = frame_len;
                        acc_d   = '0;
                        fill_d  = '0;
                        addr_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL, S_RUN: begin
                if (accept) begin
                    acc_d  = acc_q + LW'(1);
                    addr_d = (addr_q == AW'(WIN - 1)) ? '0 : addr_q + AW'(1);
                    if (fill_q != FW'(WIN)) begin
                        fill_d = fill_q + FW'(1);
                    end
                    if (last_sample) begin
                        state_d = S_FLUSH;
                    end else if ((state_q == S_FILL) && (fill_q == FW'(WIN - 1))) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                if (vpipe_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Valid tokens move in lockstep with the datapath, so they freeze on stall too.
    always_comb begin
        vpipe_d = vpipe_q;
        if (dp_en) begin
            vpipe_d[0] = calc_en;
            for (int i = 1; i < LAT; i++) begin
                vpipe_d[i] = vpipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            fill_q  <= '0;
            addr_q  <= '0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            vpipe_q <= vpipe_d;
        end
    end
endmodule

// File: tb/tb_cs_window_ctrl.sv
// Scoreboard bench for cs_window_ctrl: stimulus queues the expected write/calc sequence, a monitor pops it on every wr_en.
module tb_cs_window_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic        calc_en;
    logic        dp_en;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [3:0] addr;
        logic       calc;
    } wr_exp_t;

    wr_exp_t exp_wr[$];
    int checks = 0;
    int failures = 0;
    int res_cnt = 0;
    int done_cnt = 0;

    cs_window_ctrl #(.WIN(9), .AW(4), .LAT(1), .LW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .calc_en(calc_en), .dp_en(dp_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_calc_en"}, calc_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dp_en"}, dp_en, 1);
        check({tag, "_wr_addr"}, wr_addr, 0);
    endtask

    // Monitor: consumes one expected write per wr_en and audits output timing.
    initial begin
        wr_exp_t e;
        bit prev_calc;
        bit prev_stall;
        prev_calc = 0;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_calc = 0;
                prev_stall = 0;
            end else begin
                if (prev_calc) check("result_latency", out_valid, 1);
                if (prev_stall) check("out_valid_hold", out_valid, 1);
                if (wr_en) begin
                    check("wr_expected", int'(exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("calc_en", calc_en, e.calc);
                    end
                end else if (calc_en) begin
                    check("calc_without_wr", calc_en, 0);
                end
                if (out_valid && out_ready) res_cnt++;
                if (done) done_cnt++;
                prev_calc = calc_en;
                prev_stall = out_valid & ~out_ready;
            end
        end
    end

    task automatic run_frame(input int len, input bit gap, input bit bp, input bit mid_start,
                             input int abort_at, input int exp_res, input int exp_addr);
        int res0, done0, acc, cyc, bp_left;
        bit bp_used, mid_used, seen;
        res0 = res_cnt;
        done0 = done_cnt;
        acc = 0;
        bp_left = 0;
        bp_used = 0;
        mid_used = 0;
        seen = 0;
        for (int i = 0; i < len; i++) begin
            exp_wr.push_back('{addr: 4'(i % 9), calc: (i >= 8)});
        end
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = 16'(len);
        in_valid = !gap;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (!out_ready) begin
                check("bp_dp_en", dp_en, 0);
                check("bp_in_ready", in_ready, 0);
                check("bp_wr_en", wr_en, 0);
                check("bp_out_valid", out_valid, 1);
            end
            if (wr_en) acc++;
            if (done) begin
                seen = 1;
                break;
            end
            if (abort_at > 0 && acc == abort_at) break;
            if (bp && !bp_used && out_valid) begin
                bp_left = 3;
                bp_used = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (mid_start && !mid_used && acc == 9) begin
                start = 1'b1;
                frame_len = 16'd3;
                mid_used = 1;
            end
            out_ready = (bp_left == 0);
            if (bp_left > 0) bp_left--;
            if (gap) in_valid = !in_valid;
        end
        if (abort_at > 0) begin
            @(posedge clk); #2;
            reset = 1'b0;
            #1;
            check("abort_writes", acc, abort_at);
            check_rst("midreset");
            exp_wr.delete();
            in_valid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
        end else begin
            check("done_seen", seen, 1);
            if (len == 0) check("zero_len_done_cycle", cyc, 0);
            check("busy_at_done", busy, 1);
            if (exp_addr >= 0) check("final_wr_addr", wr_addr, exp_addr);
            check("writes_consumed", exp_wr.size(), 0);
            check("result_count", res_cnt - res0, exp_res);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
            check("done_count", done_cnt - done0, 1);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #1;
        check_rst("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        run_frame(12, 0, 0, 0, 0, 4, 3);
        run_frame(12, 0, 1, 0, 0, 4, 3);
        run_frame(5, 0, 0, 0, 0, 0, 5);
        run_frame(0, 0, 0, 0, 0, 0, -1);
        run_frame(10, 1, 0, 1, 0, 2, 1);
        run_frame(12, 0, 0, 0, 10, 0, 0);
        run_frame(9, 0, 0, 0, 0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
